tcdm_addr_demux: RTL and testbench



---
 rtl/mempool_pkg.sv | 35 +++
 rtl/demux_idx_fifo.sv | 59 +++++
 rtl/tcdm_addr_demux.sv | 142 ++++++++++++++
 tb/tb_tcdm_addr_demux.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mempool_pkg.sv
// Shared MemPool types for TCDM ports and the address map.
//   addr_t / data_t / strb_t / amo_t : TCDM request payload fields
//   address_map_t                    : one decode rule (mask, value, target)
//   tcdm_req_t / tcdm_resp_t         : bundled request and response payloads
package mempool_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = DataWidth / 8;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [BeWidth-1:0]   strb_t;
  typedef logic [3:0]           amo_t;

  typedef struct packed {
    logic [7:0] slave_idx;
    addr_t      mask;
    addr_t      value;
  } address_map_t;

  typedef struct packed {
    addr_t addr;
    logic  wen;
    data_t wdata;
    strb_t be;
    amo_t  amo;
  } tcdm_req_t;

  typedef struct packed {
    data_t rdata;
    logic  err;
  } tcdm_resp_t;

endpackage

// File: rtl/demux_idx_fifo.sv
// In-order index FIFO for demultiplexers that must return responses in
// request order.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, data_i   : enqueue an index (caller guarantees !full_o)
//   pop_i            : dequeue the head (caller guarantees !empty_o)
//   head_o           : oldest entry
//   full_o, empty_o  : occupancy flags; full_o is registered
module demux_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic [CntW-1:0]  cnt, cnt_d;
  logic             full_q;

  always_comb begin
    cnt_d = cnt;
    if (push_i && !pop_i)      cnt_d = cnt + CntW'(1);
    else if (pop_i && !push_i) cnt_d = cnt - CntW'(1);
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      full_q <= 1'b0;
    end else begin
      if (push_i) wptr <= wptr + PtrW'(1);
      if (pop_i)  rptr <= rptr + PtrW'(1);
      cnt    <= cnt_d;
      full_q <= (cnt_d == CntW'(Depth));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr] <= data_i;
  end

  assign head_o  = mem[rptr];
  assign full_o  = full_q;
  assign empty_o = (cnt == '0);

endmodule

// File: rtl/tcdm_addr_demux.sv
// TCDM request demultiplexer: decodes each request address against a rule
// table, forwards it to one of NumSlaves targets and returns responses in
// request order. Unmapped requests get a local error response and bump a
// saturating error counter.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   addr_map_i         : rule table (hold stable while requests outstanding)
//   req_* / resp_*     : upstream request / response port
//   mst_req_* / mst_resp_* : per-target request / response ports
//   err_cnt_o          : saturating decode-error count
module tcdm_addr_demux
  import mempool_pkg::*;
#(
  parameter int unsigned NumSlaves      = 4,
  parameter int unsigned NumRules       = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ErrCntWidth    = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  address_map_t [NumRules-1:0]         addr_map_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [AddrWidth-1:0]                req_addr_i,
  input  logic                                req_wen_i,
  input  logic [DataWidth-1:0]                req_wdata_i,
  input  logic [BeWidth-1:0]                  req_be_i,
  input  logic [3:0]                          req_amo_i,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic [DataWidth-1:0]                resp_rdata_o,
  output logic                                resp_err_o,
  output logic [NumSlaves-1:0]                mst_req_valid_o,
  input  logic [NumSlaves-1:0]                mst_req_ready_i,
  output logic [AddrWidth-1:0]                mst_addr_o,
  output logic                                mst_wen_o,
  output logic [DataWidth-1:0]                mst_wdata_o,
  output logic [BeWidth-1:0]                  mst_be_o,
  output logic [3:0]                          mst_amo_o,
  input  logic [NumSlaves-1:0]                mst_resp_valid_i,
  output logic [NumSlaves-1:0]                mst_resp_ready_o,
  input  logic [NumSlaves-1:0][DataWidth-1:0] mst_resp_rdata_i,
  output logic [ErrCntWidth-1:0]              err_cnt_o
);

  // Index NumSlaves is the ERR marker, hence the +1.
  localparam int unsigned    IdxW   = $clog2(NumSlaves + 1);
  localparam logic [IdxW-1:0] ErrIdx = IdxW'(NumSlaves);

  tcdm_req_t       req;
  tcdm_resp_t      resp;
  logic [IdxW-1:0] tgt, head;
  logic            hit, tgt_rdy, full, empty, push, pop;
  logic [ErrCntWidth-1:0] err_cnt_q;

  assign req = '{addr: req_addr_i, wen: req_wen_i, wdata: req_wdata_i,
                 be: req_be_i, amo: req_amo_i};

  assign mst_addr_o  = req.addr;
  assign mst_wen_o   = req.wen;
  assign mst_wdata_o = req.wdata;
  assign mst_be_o    = req.be;
  assign mst_amo_o   = req.amo;

  // Lowest-index hit wins; a winning rule pointing past the last target
  // decodes to ERR rather than falling through to later rules.
  always_comb begin
    hit = 1'b0;
    tgt = ErrIdx;
    for (int r = 0; r < int'(NumRules); r++) begin
      if (!hit && ((req.addr & addr_map_i[r].mask) == addr_map_i[r].value)) begin
        hit = 1'b1;
        if (32'(addr_map_i[r].slave_idx) < NumSlaves)
          tgt = IdxW'(addr_map_i[r].slave_idx);
      end
    end
  end

  // ERR requests are always ready (subject to FIFO space).
  always_comb begin
    tgt_rdy = 1'b1;
    mst_req_valid_o = '0;
    for (int s = 0; s < int'(NumSlaves); s++) begin
      if (tgt == IdxW'(s)) begin
        tgt_rdy            = mst_req_ready_i[s];
        mst_req_valid_o[s] = req_valid_i && !full;
      end
    end
  end

  assign req_ready_o = !full && tgt_rdy;
  assign push        = req_valid_i && req_ready_o;

  always_comb begin
    resp             = '0;
    resp_valid_o     = 1'b0;
    mst_resp_ready_o = '0;
    if (!empty) begin
      if (head == ErrIdx) begin
        resp_valid_o = 1'b1;
        resp.err     = 1'b1;
      end else begin
        for (int s = 0; s < int'(NumSlaves); s++) begin
          if (head == IdxW'(s)) begin
            resp_valid_o        = mst_resp_valid_i[s];
            resp.rdata          = mst_resp_rdata_i[s];
            mst_resp_ready_o[s] = resp_ready_i;
          end
        end
      end
    end
  end

  assign resp_rdata_o = resp.rdata;
  assign resp_err_o   = resp.err;
  assign pop          = resp_valid_o && resp_ready_i;

  demux_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (tgt),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)                                 err_cnt_q <= '0;
    else if (push && tgt == ErrIdx && ~&err_cnt_q) err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
  end

  assign err_cnt_o = err_cnt_q;

  // A target must never answer when nothing is outstanding.
  resp_without_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(empty && |mst_resp_valid_i));

endmodule

// File: tb/tb_tcdm_addr_demux.sv
module tb_tcdm_addr_demux;
  import mempool_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  address_map_t [3:0]  addr_map;
  logic                req_valid, req_ready, req_wen;
  logic [31:0]         req_addr, req_wdata;
  logic [3:0]          req_be, req_amo;
  logic                resp_valid, resp_ready, resp_err;
  logic [31:0]         resp_rdata;
  logic [3:0]          mst_req_valid, mst_req_ready;
  logic [31:0]         mst_addr, mst_wdata;
  logic                mst_wen;
  logic [3:0]          mst_be, mst_amo;
  logic [3:0]          mst_resp_valid, mst_resp_ready;
  logic [3:0][31:0]    mst_resp_rdata;
  logic [15:0]         err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcdm_addr_demux dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .addr_map_i       (addr_map),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .req_wen_i        (req_wen),
    .req_wdata_i      (req_wdata),
    .req_be_i         (req_be),
    .req_amo_i        (req_amo),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_rdata_o     (resp_rdata),
    .resp_err_o       (resp_err),
    .mst_req_valid_o  (mst_req_valid),
    .mst_req_ready_i  (mst_req_ready),
    .mst_addr_o       (mst_addr),
    .mst_wen_o        (mst_wen),
    .mst_wdata_o      (mst_wdata),
    .mst_be_o         (mst_be),
    .mst_amo_o        (mst_amo),
    .mst_resp_valid_i (mst_resp_valid),
    .mst_resp_ready_o (mst_resp_ready),
    .mst_resp_rdata_i (mst_resp_rdata),
    .err_cnt_o        (err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    addr_map[0] = '{slave_idx: 8'd0, mask: 32'hFFFF_0000, value: 32'h0000_0000};
    addr_map[1] = '{slave_idx: 8'd1, mask: 32'hFFFF_0000, value: 32'h0001_0000};
    addr_map[2] = '{slave_idx: 8'd2, mask: 32'hFFFF_FF00, value: 32'h0000_0000};
    addr_map[3] = '{slave_idx: 8'd7, mask: 32'hFFFF_FFFF, value: 32'h9000_0000};
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
    req_wdata = '0; req_be = 4'hF; req_amo = '0; resp_ready = 1'b0;
    mst_req_ready = 4'hF; mst_resp_valid = '0; mst_resp_rdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mst_req_valid", mst_req_valid, 0);
    chk("rst_mst_resp_ready", mst_resp_ready, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // basic write to slave 1, response passthrough
    req_valid = 1'b1; req_addr = 32'h0001_0004; req_wen = 1'b1; req_wdata = 32'h1234_5678;
    #1;
    chk("wr_mst_req_valid", mst_req_valid, 4'b0010);
    chk("wr_req_ready", req_ready, 1);
    chk("wr_mst_addr", mst_addr, 32'h0001_0004);
    chk("wr_mst_wdata", mst_wdata, 32'h1234_5678);
    tick();
    req_valid = 1'b0; req_wen = 1'b0;
    resp_ready = 1'b1; mst_resp_valid = 4'b0010; mst_resp_rdata[1] = 32'hDEAD_BEEF;
    #1;
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("wr_resp_err", resp_err, 0);
    chk("wr_mst_resp_ready", mst_resp_ready, 4'b0010);
    tick();
    mst_resp_valid = '0;
    #1;
    chk("wr_drained", resp_valid, 0);

    // overlapping rules 0 and 2: rule 0 wins; target stalled so not accepted
    req_valid = 1'b1; req_addr = 32'h0000_0010; mst_req_ready = 4'b1110;
    #1;
    chk("ovl_mst_req_valid", mst_req_valid, 4'b0001);
    chk("ovl_req_ready", req_ready, 0);
    req_valid = 1'b0; mst_req_ready = 4'hF;

    // unmapped address and out-of-range slave index
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    #1;
    chk("miss_mst_req_valid", mst_req_valid, 0);
    chk("miss_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("miss_resp_valid", resp_valid, 1);
    chk("miss_resp_err", resp_err, 1);
    chk("miss_resp_rdata", resp_rdata, 0);
    chk("miss_err_cnt1", err_cnt, 1);
    req_valid = 1'b1; req_addr = 32'h9000_0000;
    #1;
    chk("idx7_mst_req_valid", mst_req_valid, 0);
    tick();
    req_valid = 1'b0;
    #1;
    chk("idx7_err_cnt2", err_cnt, 2);
    resp_ready = 1'b1;
    #1;
    chk("idx7_resp_err_a", resp_err, 1);
    tick();
    chk("idx7_resp_err_b", resp_err, 1);
    tick();
    chk("idx7_drained", resp_valid, 0);

    // in-order responses: slave 1 answers before slave 0
    req_valid = 1'b1; req_addr = 32'h0000_0100;
    tick();
    req_addr = 32'h0001_0000;
    tick();
    req_valid = 1'b0;
    mst_resp_valid = 4'b0010; mst_resp_rdata[1] = 32'h0000_1111;
    #1;
    chk("ord_s1_stalled", mst_resp_ready, 4'b0001);
    chk("ord_no_resp", resp_valid, 0);
    tick();
    mst_resp_valid = 4'b0011; mst_resp_rdata[0] = 32'h0000_AAAA;
    #1;
    chk("ord_first_rdata", resp_rdata, 32'h0000_AAAA);
    chk("ord_first_ready", mst_resp_ready, 4'b0001);
    tick();
    mst_resp_valid = 4'b0010;
    #1;
    chk("ord_second_valid", resp_valid, 1);
    chk("ord_second_rdata", resp_rdata, 32'h0000_1111);
    chk("ord_second_ready", mst_resp_ready, 4'b0010);
    tick();
    mst_resp_valid = '0; resp_ready = 1'b0;
    #1;
    chk("ord_drained", resp_valid, 0);

    // fill to MaxOutstanding with responses stalled
    req_valid = 1'b1; req_addr = 32'h0000_0000;
    repeat (4) tick();
    chk("full_req_ready", req_ready, 0);
    chk("full_mst_req_valid", mst_req_valid, 0);
    resp_ready = 1'b1; mst_resp_valid = 4'b0001;
    #1;
    chk("full_no_bypass", req_ready, 0);
    chk("full_pop_valid", resp_valid, 1);
    tick();
    mst_resp_valid = '0; resp_ready = 1'b0;
    #1;
    chk("full_after_pop", req_ready, 1);
    req_valid = 1'b0;
    tick();

    // reset with 3 outstanding
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_err_cnt", err_cnt, 0);

    // error counter saturation: one miss accepted and popped per cycle
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8000_0000;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", err_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", err_cnt, 16'hFFFF);
    repeat (3) tick();
    chk("sat_hold", err_cnt, 16'hFFFF);
    req_valid = 1'b0;
    tick();
    tick();
    chk("sat_drained", resp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
